// File: rtl/openddr_page_ctrl.sv
// openddr_page_ctrl: per-bank open-page controller.
// Accepts one decoded request at a time, tracks the open row of every bank and
// issues the minimal PRE/ACT/RD/WR sequence with tRP/tRCD spacing. Also closes
// every bank on a precharge-all request (used ahead of refresh).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds valid and its payload stable until that edge and may
// drop valid only in the cycle after it. req_ready is the only output that
// depends combinationally on an input (pre_all_req); every other output is a
// register.
module openddr_page_ctrl #(
    parameter int BANK_WIDTH = 3,
    parameter int ROW_WIDTH  = 16,
    parameter int COL_WIDTH  = 10,
    parameter int T_RP       = 4,
    parameter int T_RCD      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BANK_WIDTH-1:0] req_bank,
    input  logic [ROW_WIDTH-1:0]  req_row,
    input  logic [COL_WIDTH-1:0]  req_col,
    input  logic                  req_write,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [2:0]            cmd_type,
    output logic [BANK_WIDTH-1:0] cmd_bank,
    output logic [ROW_WIDTH-1:0]  cmd_row,
    output logic [COL_WIDTH-1:0]  cmd_col,
    input  logic                  pre_all_req,
    output logic                  pre_all_done,
    output logic                  hit,
    output logic                  miss,
    output logic                  conflict
);

    localparam int NB    = 1 << BANK_WIDTH;
    localparam int T_MAX = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int CW    = $clog2(T_MAX);

    localparam logic [2:0] CMD_ACT  = 3'd0;
    localparam logic [2:0] CMD_PRE  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PREA = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DECIDE,
        S_PRE,
        S_WAIT_RP,
        S_ACT,
        S_WAIT_RCD,
        S_RW,
        S_PREA,
        S_WAIT_PA,
        S_PA_DONE
    } state_t;

    state_t                 state;
    logic [NB-1:0]          open_q;
    logic [ROW_WIDTH-1:0]   open_row_q [NB];
    logic [BANK_WIDTH-1:0]  bank_q;
    logic [ROW_WIDTH-1:0]   row_q;
    logic [COL_WIDTH-1:0]   col_q;
    logic                   write_q;
    logic [CW-1:0]          wait_cnt;

    logic req_fire;
    logic cmd_fire;
    logic req_open;
    logic req_match;

    assign req_ready = (state == S_IDLE) && !pre_all_req;
    assign req_fire  = req_valid && req_ready;
    assign cmd_fire  = cmd_valid && cmd_ready;
    // Classification is taken from the incoming request at acceptance so the
    // pulses are registered and line up with the DECIDE cycle.
    assign req_open  = open_q[req_bank];
    assign req_match = (open_row_q[req_bank] == req_row);

    // Row table: a bank's row is recorded when its ACT is consumed; the open
    // bit (reset-cleared) qualifies it, so the row storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (state == S_ACT && cmd_fire) begin
            open_row_q[bank_q] <= row_q;
        end
    end

    // Main sequencer: command issue, wait timing, open-bit bookkeeping, pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            open_q       <= '0;
            bank_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            write_q      <= 1'b0;
            wait_cnt     <= '0;
            cmd_valid    <= 1'b0;
            cmd_type     <= 3'd0;
            cmd_bank     <= '0;
            cmd_row      <= '0;
            cmd_col      <= '0;
            pre_all_done <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            conflict     <= 1'b0;
        end else begin
            pre_all_done <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            conflict     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pre_all_req) begin
                        if (|open_q) begin
                            state     <= S_PREA;
                            cmd_valid <= 1'b1;
                            cmd_type  <= CMD_PREA;
                            cmd_bank  <= '0;
                            cmd_row   <= '0;
                            cmd_col   <= '0;
                        end else begin
                            state        <= S_PA_DONE;
                            pre_all_done <= 1'b1;
                        end
                    end else if (req_fire) begin
                        bank_q   <= req_bank;
                        row_q    <= req_row;
                        col_q    <= req_col;
                        write_q  <= req_write;
                        hit      <= req_open && req_match;
                        conflict <= req_open && !req_match;
                        miss     <= !req_open;
                        state    <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    cmd_valid <= 1'b1;
                    cmd_bank  <= bank_q;
                    if (hit) begin
                        state    <= S_RW;
                        cmd_type <= write_q ? CMD_WR : CMD_RD;
                        cmd_row  <= '0;
                        cmd_col  <= col_q;
                    end else if (conflict) begin
                        state    <= S_PRE;
                        cmd_type <= CMD_PRE;
                        cmd_row  <= '0;
                        cmd_col  <= '0;
                    end else begin
                        state    <= S_ACT;
                        cmd_type <= CMD_ACT;
                        cmd_row  <= row_q;
                        cmd_col  <= '0;
                    end
                end
                S_PRE: begin
                    if (cmd_fire) begin
                        open_q[bank_q] <= 1'b0;
                        cmd_valid      <= 1'b0;
                        cmd_type       <= 3'd0;
                        cmd_bank       <= '0;
                        wait_cnt       <= CW'(T_RP - 2);
                        state          <= S_WAIT_RP;
                    end
                end
                S_WAIT_RP: begin
                    if (wait_cnt == '0) begin
                        state     <= S_ACT;
                        cmd_valid <= 1'b1;
                        cmd_type  <= CMD_ACT;
                        cmd_bank  <= bank_q;
                        cmd_row   <= row_q;
                        cmd_col   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_ACT: begin
                    if (cmd_fire) begin
                        open_q[bank_q] <= 1'b1;
                        cmd_valid      <= 1'b0;
                        cmd_type       <= 3'd0;
                        cmd_bank       <= '0;
                        cmd_row        <= '0;
                        wait_cnt       <= CW'(T_RCD - 2);
                        state          <= S_WAIT_RCD;
                    end
                end
                S_WAIT_RCD: begin
                    if (wait_cnt == '0) begin
                        state     <= S_RW;
                        cmd_valid <= 1'b1;
                        cmd_type  <= write_q ? CMD_WR : CMD_RD;
                        cmd_bank  <= bank_q;
                        cmd_row   <= '0;
                        cmd_col   <= col_q;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_RW: begin
                    // Row stays open after the access (open-page policy).
                    if (cmd_fire) begin
                        cmd_valid <= 1'b0;
                        cmd_type  <= 3'd0;
                        cmd_bank  <= '0;
                        cmd_col   <= '0;
                        state     <= S_IDLE;
                    end
                end
                S_PREA: begin
                    if (cmd_fire) begin
                        open_q    <= '0;
                        cmd_valid <= 1'b0;
                        cmd_type  <= 3'd0;
                        wait_cnt  <= CW'(T_RP - 2);
                        state     <= S_WAIT_PA;
                    end
                end
                S_WAIT_PA: begin
                    if (wait_cnt == '0) begin
                        state        <= S_PA_DONE;
                        pre_all_done <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_PA_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_openddr_page_ctrl.sv
// Directed bench for openddr_page_ctrl (default parameters, T_RP = T_RCD = 4).
// Cycle numbering: cycle 0 is the cycle whose closing edge accepts the request;
// outputs are sampled 1 time unit after each rising edge.
module tb_openddr_page_ctrl;

    localparam int BW = 3;
    localparam int RW = 16;
    localparam int CWD = 10;

    localparam logic [2:0] CT_ACT  = 3'd0;
    localparam logic [2:0] CT_PRE  = 3'd1;
    localparam logic [2:0] CT_RD   = 3'd2;
    localparam logic [2:0] CT_WR   = 3'd3;
    localparam logic [2:0] CT_PREA = 3'd4;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [BW-1:0]   req_bank;
    logic [RW-1:0]   req_row;
    logic [CWD-1:0]  req_col;
    logic            req_write;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_type;
    logic [BW-1:0]   cmd_bank;
    logic [RW-1:0]   cmd_row;
    logic [CWD-1:0]  cmd_col;
    logic            pre_all_req;
    logic            pre_all_done;
    logic            hit;
    logic            miss;
    logic            conflict;

    int n_cmp = 0;
    int n_err = 0;

    openddr_page_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_bank     (req_bank),
        .req_row      (req_row),
        .req_col      (req_col),
        .req_write    (req_write),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_bank     (cmd_bank),
        .cmd_row      (cmd_row),
        .cmd_col      (cmd_col),
        .pre_all_req  (pre_all_req),
        .pre_all_done (pre_all_done),
        .hit          (hit),
        .miss         (miss),
        .conflict     (conflict)
    );

    // Clock and a global time limit.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cmd_now();
        return {31'd0, cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_col};
    endfunction

    task automatic expect_cmd(input string tag, input logic [2:0] t, input logic [BW-1:0] b,
                              input logic [RW-1:0] r, input logic [CWD-1:0] c);
        chk(tag, cmd_now(), {31'd0, 1'b1, t, b, r, c});
    endtask

    // Presents a request and lets it be accepted; returns in cycle 1.
    task automatic do_req(input logic [BW-1:0] b, input logic [RW-1:0] r,
                          input logic [CWD-1:0] c, input logic w);
        req_valid = 1'b1;
        req_bank  = b;
        req_row   = r;
        req_col   = c;
        req_write = w;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_bank    = '0;
        req_row     = '0;
        req_col     = '0;
        req_write   = 1'b0;
        cmd_ready   = 1'b1;
        pre_all_req = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_cmd", cmd_now(), 64'd0);
        chk("rst_pulses", 64'({pre_all_done, hit, miss, conflict}), 64'd0);
        rst = 1'b0;
        tick();

        // Cold miss: ACT at 2, RD at 6
        do_req(3'd2, 16'h1234, 10'h010, 1'b0);
        chk("cold_cls", 64'({hit, miss, conflict}), 64'b010);
        chk("cold_c1_idle", 64'(cmd_valid), 64'd0);
        tick();
        expect_cmd("cold_act", CT_ACT, 3'd2, 16'h1234, 10'h0);
        tick();
        chk("cold_c3_quiet", 64'({hit, miss, conflict, cmd_valid}), 64'd0);
        tick();
        tick();
        chk("cold_c5_quiet", 64'(cmd_valid), 64'd0);
        tick();
        expect_cmd("cold_rd", CT_RD, 3'd2, 16'h0, 10'h010);
        tick();
        chk("cold_done_ready", 64'({req_ready, cmd_valid}), 64'b10);

        // Hit: WR at cycle 2, no ACT
        do_req(3'd2, 16'h1234, 10'h020, 1'b1);
        chk("hit_cls", 64'({hit, miss, conflict}), 64'b100);
        tick();
        expect_cmd("hit_wr", CT_WR, 3'd2, 16'h0, 10'h020);
        tick();
        chk("hit_done", 64'(cmd_valid), 64'd0);

        // Conflict: PRE at 2, ACT at 6, RD at 10
        do_req(3'd2, 16'h5555, 10'h030, 1'b0);
        chk("conf_cls", 64'({hit, miss, conflict}), 64'b001);
        tick();
        expect_cmd("conf_pre", CT_PRE, 3'd2, 16'h0, 10'h0);
        tick();
        chk("conf_c3_quiet", 64'(cmd_valid), 64'd0);
        tick();
        tick();
        chk("conf_c5_quiet", 64'(cmd_valid), 64'd0);
        tick();
        expect_cmd("conf_act", CT_ACT, 3'd2, 16'h5555, 10'h0);
        tick();
        tick();
        tick();
        chk("conf_c9_quiet", 64'(cmd_valid), 64'd0);
        tick();
        expect_cmd("conf_rd", CT_RD, 3'd2, 16'h0, 10'h030);
        tick();

        // Backpressure on ACT for cycles 2..6, handshake at 7, RD at 11
        cmd_ready = 1'b0;
        do_req(3'd5, 16'h0abc, 10'h3ff, 1'b0);
        chk("bp_cls", 64'({hit, miss, conflict}), 64'b010);
        tick();
        for (int i = 0; i < 5; i++) begin
            expect_cmd($sformatf("bp_act_hold%0d", i), CT_ACT, 3'd5, 16'h0abc, 10'h0);
            tick();
        end
        expect_cmd("bp_act_hs", CT_ACT, 3'd5, 16'h0abc, 10'h0);
        cmd_ready = 1'b1;
        tick();
        chk("bp_c8_quiet", 64'(cmd_valid), 64'd0);
        tick();
        tick();
        chk("bp_c10_quiet", 64'(cmd_valid), 64'd0);
        tick();
        expect_cmd("bp_rd", CT_RD, 3'd5, 16'h0, 10'h3ff);
        tick();

        // Open banks 1 and 3
        for (int b = 1; b <= 3; b += 2) begin
            do_req(3'(b), 16'h0100 + 16'(b), 10'h001, 1'b0);
            chk($sformatf("open%0d_cls", b), 64'({hit, miss, conflict}), 64'b010);
            tick();
            expect_cmd($sformatf("open%0d_act", b), CT_ACT, 3'(b), 16'h0100 + 16'(b), 10'h0);
            tick();
            tick();
            tick();
            tick();
            expect_cmd($sformatf("open%0d_rd", b), CT_RD, 3'(b), 16'h0, 10'h001);
            tick();
        end

        // Precharge-all with a request pending: PREA handshake at cycle 1,
        // done pulse T_RP cycles later (cycle 5), then the request is a miss.
        pre_all_req = 1'b1;
        req_valid   = 1'b1;
        req_bank    = 3'd1;
        req_row     = 16'h0101;
        req_col     = 10'h005;
        req_write   = 1'b0;
        #1;
        chk("pa_req_ready_low", 64'(req_ready), 64'd0);
        tick();
        expect_cmd("pa_prea", CT_PREA, 3'd0, 16'h0, 10'h0);
        pre_all_req = 1'b0;
        tick();
        chk("pa_c2_quiet", 64'(cmd_valid), 64'd0);
        tick();
        tick();
        chk("pa_c4_notdone", 64'({pre_all_done, cmd_valid}), 64'd0);
        tick();
        chk("pa_done", 64'({pre_all_done, cmd_valid}), 64'b10);
        tick();
        chk("pa_done_single", 64'({pre_all_done, req_ready}), 64'b01);
        tick();
        req_valid = 1'b0;
        chk("pa_next_miss", 64'({hit, miss, conflict}), 64'b010);
        tick();
        expect_cmd("pa_next_act", CT_ACT, 3'd1, 16'h0101, 10'h0);
        tick();
        tick();
        tick();
        tick();
        expect_cmd("pa_next_rd", CT_RD, 3'd1, 16'h0, 10'h005);
        tick();

        // Reset while in WAIT_RCD
        do_req(3'd6, 16'h7777, 10'h001, 1'b1);
        chk("rmid_cls", 64'({hit, miss, conflict}), 64'b010);
        tick();
        expect_cmd("rmid_act", CT_ACT, 3'd6, 16'h7777, 10'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("rmid_rst_outputs", 64'({req_ready, cmd_valid}), 64'b10);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rmid_quiet%0d", i), 64'(cmd_valid), 64'd0);
        end
        do_req(3'd6, 16'h7777, 10'h001, 1'b1);
        chk("rmid_again_miss", 64'({hit, miss, conflict}), 64'b010);
        tick();
        expect_cmd("rmid_again_act", CT_ACT, 3'd6, 16'h7777, 10'h0);
        tick();
        tick();
        tick();
        tick();
        expect_cmd("rmid_again_wr", CT_WR, 3'd6, 16'h0, 10'h001);
        tick();

        // Reset while a command is held valid: cmd_valid drops immediately
        cmd_ready = 1'b0;
        do_req(3'd0, 16'h0001, 10'h000, 1'b0);
        tick();
        expect_cmd("rval_act", CT_ACT, 3'd0, 16'h0001, 10'h0);
        rst = 1'b1;
        #1;
        chk("rval_drop", cmd_now(), 64'd0);
        tick();
        rst = 1'b0;
        cmd_ready = 1'b1;
        tick();

        // Precharge-all with nothing open: done at cycle 1, no command
        pre_all_req = 1'b1;
        tick();
        chk("pa_none_done", 64'({pre_all_done, cmd_valid}), 64'b10);
        pre_all_req = 1'b0;
        tick();
        chk("pa_none_after", 64'({pre_all_done, cmd_valid, req_ready}), 64'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
